// File: rtl/wd_out_collector.sv
// WD output collector: groups WD result words into bursts, queues them in a
// first-word-fall-through FIFO, and keeps per-burst maximum and burst count.
module wd_out_collector #(
   parameter int unsigned DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [4:0]  result,
   input  logic [10:0] out_value,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [15:0] out_data,
   output logic        out_last,
   output logic [10:0] max_value,
   output logic [7:0]  burst_cnt,
   output logic        overflow
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned EW = 17;

   typedef enum logic {IDLE, PEND} state_t;

   state_t        state;
   logic [15:0]   pend_word;
   logic [10:0]   run_max;
   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic          push_c;
   logic          push_last_c;
   logic [EW-1:0] push_entry_c;
   logic          pop_c;
   logic          full_c;
   logic          wr_en_c;
   logic [PW-1:0] rd_nxt_c;
   logic [CW-1:0] count_nxt_c;
   logic [EW-1:0] head_nxt_c;
   logic [10:0]   max_upd_c;

   // Push/pop decisions and the next head entry for the registered outputs.
   always_comb begin
      push_c       = (state == PEND);
      push_last_c  = ~in_valid;
      push_entry_c = {push_last_c, pend_word};
      pop_c        = out_valid & out_ready;
      full_c       = (count == CW'(DEPTH));
      wr_en_c      = push_c & (~full_c | pop_c);
      rd_nxt_c     = pop_c ? rd_ptr + PW'(1) : rd_ptr;
      count_nxt_c  = count;
      if (wr_en_c && !pop_c)
         count_nxt_c = count + CW'(1);
      else if (!wr_en_c && pop_c)
         count_nxt_c = count - CW'(1);
      head_nxt_c = mem[rd_nxt_c];
      if (wr_en_c && (wr_ptr == rd_nxt_c))
         head_nxt_c = push_entry_c;
      max_upd_c = (out_value > run_max) ? out_value : run_max;
   end

   // Burst FSM: pending word capture, running maximum and burst statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pend_word <= '0;
         run_max   <= '0;
         max_value <= '0;
         burst_cnt <= '0;
         overflow  <= 1'b0;
      end else begin
         if (push_c && full_c && !pop_c)
            overflow <= 1'b1;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  pend_word <= {result, out_value};
                  run_max   <= out_value;
                  state     <= PEND;
               end
            end
            PEND: begin
               if (in_valid) begin
                  pend_word <= {result, out_value};
                  run_max   <= max_upd_c;
               end else begin
                  max_value <= run_max;
                  burst_cnt <= burst_cnt + 8'(1);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO storage, pointers, occupancy and registered head outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++)
            mem[i] <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         if (wr_en_c) begin
            mem[wr_ptr] <= push_entry_c;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         rd_ptr    <= rd_nxt_c;
         count     <= count_nxt_c;
         out_valid <= (count_nxt_c != '0);
         if (count_nxt_c != '0) begin
            out_data <= head_nxt_c[15:0];
            out_last <= head_nxt_c[16];
         end
      end
   end

endmodule
